mem_loader: RTL

//  Host-side initiator for the cpu external memory ports (addr_ext/wen_ext/ren_ext/wdata_ext, *_2).

---
 rtl/mem_loader_pkg.sv | 35 +++
 rtl/mem_loader_if.sv | 38 +++
 rtl/mem_loader_tx_serializer.sv | 47 ++++
 rtl/mem_loader.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// mem_loader_pkg : opcodes, FSM states and word sizes shared by the loader
// Revision 1.0
// ----------------------------------------------------------------------------
package mem_loader_pkg;

   localparam logic [7:0] c_op_imem_wr = 8'h01;
   localparam logic [7:0] c_op_dmem_wr = 8'h02;
   localparam logic [7:0] c_op_dmem_rd = 8'h03;
   localparam logic [7:0] c_op_run     = 8'h04;
   localparam logic [7:0] c_op_halt    = 8'h05;

   localparam int c_imem_bytes = 4;
   localparam int c_dmem_bytes = 8;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_IDX0    = 4'd1,
      S_IDX1    = 4'd2,
      S_CNT     = 4'd3,
      S_WDATA   = 4'd4,
      S_WRITE   = 4'd5,
      S_RD_REQ  = 4'd6,
      S_RD_WAIT = 4'd7,
      S_TX      = 4'd8
   } state_t;

   function automatic logic [2:0] last_byte(input logic is_imem);
      return is_imem ? 3'(c_imem_bytes - 1) : 3'(c_dmem_bytes - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_loader_if.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// mem_loader_if : byte streams plus cpu external memory ports of the loader
// Revision 1.0
// ----------------------------------------------------------------------------
interface mem_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [63:0] imem_addr;
   logic        imem_wen;
   logic        imem_ren;
   logic [31:0] imem_wdata;
   logic [63:0] dmem_addr;
   logic        dmem_wen;
   logic        dmem_ren;
   logic [63:0] dmem_wdata;
   logic [63:0] dmem_rdata;

   modport master (
      input  rx_data, rx_valid, tx_ready, dmem_rdata,
      output rx_ready, tx_data, tx_valid,
      output imem_addr, imem_wen, imem_ren, imem_wdata,
      output dmem_addr, dmem_wen, dmem_ren, dmem_wdata
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, dmem_rdata,
      input  rx_ready, tx_data, tx_valid,
      input  imem_addr, imem_wen, imem_ren, imem_wdata,
      input  dmem_addr, dmem_wen, dmem_ren, dmem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_loader_tx_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// mem_loader_tx_serializer : sends a loaded 64b word as 8 bytes, LSB first
// Revision 1.0
// ----------------------------------------------------------------------------
module mem_loader_tx_serializer (
   input  wire logic        clk,
   input  wire logic        arst_n,
   input  wire logic        load,
   input  wire logic [63:0] load_data,
   output logic      [7:0]  tx_data,
   output logic             tx_valid,
   input  wire logic        tx_ready,
   output logic             done
);
   logic [63:0] r_shift;
   logic [2:0]  r_count;
   logic        r_valid;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_shift <= '0;
         r_count <= '0;
         r_valid <= 1'b0;
      end else if (load) begin
         r_shift <= load_data;
         r_count <= '0;
         r_valid <= 1'b1;
      end else if (r_valid && tx_ready) begin
         if (r_count == 3'd7) begin
            r_shift <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
         end else begin
            r_shift <= {8'h00, r_shift[63:8]};
            r_count <= r_count + 3'd1;
         end
      end
   end

   // shift register is zeroed when idle, so tx_data reads 0 without valid
   assign tx_data  = r_shift[7:0];
   assign tx_valid = r_valid;
   assign done     = r_valid & tx_ready & (r_count == 3'd7);
endmodule
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// mem_loader : byte-command initiator that loads/reads cpu memories, run/halt
// Revision 1.0
// ----------------------------------------------------------------------------
module mem_loader
   import mem_loader_pkg::*;
#(
   parameter int IMEM_ADDR_W = 9,
   parameter int DMEM_ADDR_W = 10
) (
   input  wire logic     clk,
   input  wire logic     arst_n,
   mem_loader_if.master  bus,
   output logic          cpu_enable,
   output logic          busy,
   output logic          err
);
   state_t      r_state, w_next;
   logic        r_ready_en;
   logic        r_is_imem;
   logic        r_is_rd;
   logic [15:0] r_idx;
   logic [7:0]  r_cnt;
   logic [2:0]  r_byte;
   logic [63:0] r_wbuf;
   logic        r_cpu_enable;
   logic        r_err;
   logic        w_rx_acc;
   logic        w_rx_fire;
   logic        w_ser_load;
   logic        w_ser_done;

   // r_ready_en keeps rx_ready low while reset is asserted
   assign w_rx_acc  = r_ready_en &
                      (r_state inside {S_IDLE, S_IDX0, S_IDX1, S_CNT, S_WDATA});
   assign w_rx_fire = w_rx_acc & bus.rx_valid;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next          = r_state;
      w_ser_load      = 1'b0;
      bus.imem_addr   = '0;
      bus.imem_wen    = 1'b0;
      bus.imem_ren    = 1'b0;
      bus.imem_wdata  = '0;
      bus.dmem_addr   = '0;
      bus.dmem_wen    = 1'b0;
      bus.dmem_ren    = 1'b0;
      bus.dmem_wdata  = '0;
      case (r_state)
         S_IDLE: begin
            if (w_rx_fire && (bus.rx_data inside {c_op_imem_wr, c_op_dmem_wr, c_op_dmem_rd}))
               w_next = S_IDX0;
         end
         S_IDX0: if (w_rx_fire) w_next = S_IDX1;
         S_IDX1: if (w_rx_fire) w_next = S_CNT;
         S_CNT:  if (w_rx_fire) w_next = r_is_rd ? S_RD_REQ : S_WDATA;
         S_WDATA: begin
            if (w_rx_fire && (r_byte == last_byte(r_is_imem)))
               w_next = S_WRITE;
         end
         S_WRITE: begin
            if (r_is_imem) begin
               bus.imem_wen   = 1'b1;
               bus.imem_addr  = 64'({r_idx[IMEM_ADDR_W-1:0], 2'b00});
               bus.imem_wdata = r_wbuf[31:0];
            end else begin
               bus.dmem_wen   = 1'b1;
               bus.dmem_addr  = 64'({r_idx[DMEM_ADDR_W-1:0], 3'b000});
               bus.dmem_wdata = r_wbuf;
            end
            w_next = (r_cnt == 8'd0) ? S_IDLE : S_WDATA;
         end
         S_RD_REQ: begin
            bus.dmem_ren  = 1'b1;
            bus.dmem_addr = 64'({r_idx[DMEM_ADDR_W-1:0], 3'b000});
            w_next        = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            w_ser_load = 1'b1;
            w_next     = S_TX;
         end
         S_TX: begin
            if (w_ser_done) w_next = (r_cnt == 8'd0) ? S_IDLE : S_RD_REQ;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_ready_en   <= 1'b0;
         r_is_imem    <= 1'b0;
         r_is_rd      <= 1'b0;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_byte       <= '0;
         r_wbuf       <= '0;
         r_cpu_enable <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_ready_en <= 1'b1;
         r_err      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_rx_fire) begin
                  case (bus.rx_data)
                     c_op_imem_wr: begin
                        r_is_imem <= 1'b1; r_is_rd <= 1'b0; r_cpu_enable <= 1'b0;
                     end
                     c_op_dmem_wr: begin
                        r_is_imem <= 1'b0; r_is_rd <= 1'b0; r_cpu_enable <= 1'b0;
                     end
                     c_op_dmem_rd: begin
                        r_is_imem <= 1'b0; r_is_rd <= 1'b1; r_cpu_enable <= 1'b0;
                     end
                     c_op_run:  r_cpu_enable <= 1'b1;
                     c_op_halt: r_cpu_enable <= 1'b0;
                     default:   r_err <= 1'b1;
                  endcase
               end
            end
            S_IDX0: if (w_rx_fire) r_idx[7:0]  <= bus.rx_data;
            S_IDX1: if (w_rx_fire) r_idx[15:8] <= bus.rx_data;
            S_CNT: begin
               if (w_rx_fire) begin
                  r_cnt  <= bus.rx_data;
                  r_byte <= '0;
                  r_wbuf <= '0;
               end
            end
            S_WDATA: begin
               if (w_rx_fire) begin
                  r_wbuf[{r_byte, 3'b000} +: 8] <= bus.rx_data;
                  r_byte <= r_byte + 3'd1;
               end
            end
            S_WRITE: begin
               r_idx  <= r_idx + 16'd1;
               r_byte <= '0;
               r_wbuf <= '0;
               if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
            end
            S_TX: begin
               if (w_ser_done) begin
                  r_idx <= r_idx + 16'd1;
                  if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   mem_loader_tx_serializer u_tx_ser (
      .clk       (clk),
      .arst_n    (arst_n),
      .load      (w_ser_load),
      .load_data (bus.dmem_rdata),
      .tx_data   (bus.tx_data),
      .tx_valid  (bus.tx_valid),
      .tx_ready  (bus.tx_ready),
      .done      (w_ser_done)
   );

   assign bus.rx_ready = w_rx_acc;
   assign cpu_enable   = r_cpu_enable;
   assign busy         = (r_state != S_IDLE);
   assign err          = r_err;
endmodule
`default_nettype wire
